// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM
// masters; read tags follow the fixed RAM latency back to the owning port.
module onchip_mem_arbiter #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 64,
   parameter int BE_W       = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic req0, req1;
   logic gnt0, gnt1;
   logic last_grant_q, last_grant_d;
   logic rd_acc;
   logic [RD_LATENCY-1:0] vld_q;
   logic [RD_LATENCY-1:0] prt_q;

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;

   // On contention the port that did not win last time is served.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (req0 && req1) begin
            gnt0 = last_grant_q;
            gnt1 = ~last_grant_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt0) last_grant_d = 1'b0;
      else if (gnt1) last_grant_d = 1'b1;
   end

   assign m0_waitrequest = reset | gnt1;
   assign m1_waitrequest = reset | gnt0;

   assign mem_chipselect = gnt0 | gnt1;
   assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
   assign mem_address    = gnt1 ? m1_address    : m0_address;
   assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;

   // A read+write command is treated as a write and gets no response.
   assign rd_acc = (gnt0 & m0_read & ~m0_write)
                 | (gnt1 & m1_read & ~m1_write);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         vld_q        <= '0;
         prt_q        <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         vld_q[0]     <= rd_acc;
         prt_q[0]     <= gnt1;
         for (int i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            prt_q[i] <= prt_q[i-1];
         end
      end
   end

   assign m0_readdatavalid = ~reset & vld_q[RD_LATENCY-1]
                           & ~prt_q[RD_LATENCY-1];
   assign m1_readdatavalid = ~reset & vld_q[RD_LATENCY-1]
                           & prt_q[RD_LATENCY-1];

   assign m0_readdata = mem_readdata;
   assign m1_readdata = mem_readdata;

endmodule
